fifo_word_reader: RTL and testbench

- Consumer-side block for the 8-bit FIFO1 wrapper.
- Drains bytes from the FIFO read port (FIFO_EMPTY/FIFO_DATA/FIFO_RD_EN) and packs them little-endian into BYTES-wide words.
- Presents packed words on a valid/ready output handshake.
- Supports a flush of partial words and a clear that also clears the upstream FIFO.

---
 rtl/fifo_word_reader_pkg.sv | 17 +
 rtl/fifo_word_reader_if.sv | 30 +++
 rtl/fifo_word_reader_packer.sv | 73 +++++++
 rtl/fifo_word_reader.sv | 89 ++++++++
 tb/tb_fifo_word_reader.sv | 333 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_word_reader_pkg.sv
// Shared types and constants for the FIFO word reader: FSM states, default
// data width and the byte-count width helper.
package fifo_if_pkg;

    localparam int FIFO_DATA_W = 8;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    // Width able to hold a byte count of 0..bytes inclusive.
    function automatic int cntWidth(input int bytes);
        return $clog2(bytes + 1);
    endfunction

endpackage

// File: rtl/fifo_word_reader_if.sv
// FIFO read port plus packed-word valid/ready handshake; master is the
// reader block, slave is the FIFO/downstream environment.
interface fifo_word_reader_if
    import fifo_if_pkg::*;
#(
    parameter int DATA_W = FIFO_DATA_W,
    parameter int BYTES  = 4
);
    localparam int BW = cntWidth(BYTES);

    logic [DATA_W-1:0]       fifo_data;
    logic                    fifo_empty;
    logic                    fifo_rd_en;
    logic                    fifo_clr;
    logic [DATA_W*BYTES-1:0] word_out;
    logic [BW-1:0]           word_bytes;
    logic                    word_valid;
    logic                    word_ready;

    modport master (
        input  fifo_data, fifo_empty, word_ready,
        output fifo_rd_en, fifo_clr, word_out, word_bytes, word_valid
    );

    modport slave (
        output fifo_data, fifo_empty, word_ready,
        input  fifo_rd_en, fifo_clr, word_out, word_bytes, word_valid
    );

endinterface

// File: rtl/fifo_word_reader_packer.sv
// Little-endian byte packer: writes accepted bytes into successive lanes and
// reports when the current word closes (full, or flushed with data).
module fifo_byte_packer
    import fifo_if_pkg::*;
#(
    parameter int DATA_W = FIFO_DATA_W,
    parameter int BYTES  = 4,
    localparam int CW    = cntWidth(BYTES)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    accept_i,
    input  logic [DATA_W-1:0]       data_i,
    input  logic                    flush_i,
    input  logic                    clear_i,
    input  logic                    release_i,
    output logic [DATA_W*BYTES-1:0] word_o,
    output logic [CW-1:0]           bytes_o,
    output logic                    close_o
);

    logic [CW-1:0]           cnt_q, cnt_d;
    logic [CW-1:0]           bytes_q, bytes_d;
    logic [DATA_W*BYTES-1:0] word_q, word_d;
    logic [CW-1:0]           cntInc;

    assign cntInc = cnt_q + CW'(1);

    // A byte popped together with FLUSH belongs to the flushed word.
    always_comb begin
        cnt_d   = cnt_q;
        bytes_d = bytes_q;
        word_d  = word_q;
        close_o = 1'b0;
        if (clear_i || release_i) begin
            cnt_d   = '0;
            bytes_d = '0;
            word_d  = '0;
        end else begin
            if (accept_i) begin
                for (int i = 0; i < BYTES; i++) begin
                    if (cnt_q == CW'(i)) begin
                        word_d[i*DATA_W +: DATA_W] = data_i;
                    end
                end
                cnt_d = cntInc;
            end
            if (accept_i && (cntInc == CW'(BYTES))) begin
                close_o = 1'b1;
                bytes_d = CW'(BYTES);
            end else if (flush_i && (accept_i || (cnt_q != '0))) begin
                close_o = 1'b1;
                bytes_d = accept_i ? cntInc : cnt_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            bytes_q <= '0;
            word_q  <= '0;
        end else begin
            cnt_q   <= cnt_d;
            bytes_q <= bytes_d;
            word_q  <= word_d;
        end
    end

    assign word_o  = word_q;
    assign bytes_o = bytes_q;

endmodule

// File: rtl/fifo_word_reader.sv
// Drains an 8-bit FIFO into BYTES-wide words and offers them on a valid/ready
// handshake; supports partial-word flush and a clear that also clears the FIFO.
module fifo_word_reader
    import fifo_if_pkg::*;
#(
    parameter int DATA_W = FIFO_DATA_W,
    parameter int BYTES  = 4,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] word_cnt_o,
    fifo_word_reader_if.master bus
);

    localparam int CW = cntWidth(BYTES);

    state_t                  state_q, state_d;
    logic                    fifoClr_q;
    logic [CNT_W-1:0]        wordCnt_q, wordCnt_d;
    logic                    rdEn;
    logic                    wordTaken;
    logic                    close;
    logic                    fillFlush;
    logic [DATA_W*BYTES-1:0] packedWord;
    logic [CW-1:0]           packedBytes;

    // Popping is only legal while filling; CLR and reset block it outright.
    assign rdEn      = (state_q == ST_FILL) & ~bus.fifo_empty & ~clr_i & ~rst;
    assign wordTaken = (state_q == ST_HOLD) & bus.word_ready & ~clr_i;
    assign fillFlush = (state_q == ST_FILL) & flush_i;

    fifo_byte_packer #(
        .DATA_W (DATA_W),
        .BYTES  (BYTES)
    ) u_packer (
        .clk       (clk),
        .rst       (rst),
        .accept_i  (rdEn),
        .data_i    (bus.fifo_data),
        .flush_i   (fillFlush),
        .clear_i   (clr_i),
        .release_i (wordTaken),
        .word_o    (packedWord),
        .bytes_o   (packedBytes),
        .close_o   (close)
    );

    always_comb begin
        state_d   = state_q;
        wordCnt_d = wordCnt_q;
        if (clr_i) begin
            state_d = ST_FILL;
        end else begin
            unique case (state_q)
                ST_FILL: if (close) state_d = ST_HOLD;
                ST_HOLD: begin
                    if (bus.word_ready) begin
                        state_d   = ST_FILL;
                        wordCnt_d = wordCnt_q + CNT_W'(1);
                    end
                end
                default: state_d = ST_FILL;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_FILL;
            wordCnt_q <= '0;
            fifoClr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wordCnt_q <= wordCnt_d;
            fifoClr_q <= clr_i;
        end
    end

    assign bus.fifo_rd_en = rdEn;
    assign bus.fifo_clr   = fifoClr_q;
    assign bus.word_out   = packedWord;
    assign bus.word_bytes = packedBytes;
    assign bus.word_valid = (state_q == ST_HOLD);
    assign word_cnt_o     = wordCnt_q;

endmodule

// File: tb/tb_fifo_word_reader.sv
// Directed and randomized bench for fifo_word_reader with a queue-based FIFO
// model and a word-level reference built from the pushed byte stream.
module tb_fifo_word_reader;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        clr;
    logic [15:0] wordCnt;
    logic [1:0]  wordCnt2;

    int checks = 0;
    int errors = 0;
    int expCnt = 0;

    logic [7:0]  fq[$];
    logic [34:0] gotQ[$];
    logic [34:0] expQ[$];
    logic [7:0]  randBytes[$];

    fifo_word_reader_if #(.DATA_W(8), .BYTES(4)) ifc ();
    fifo_word_reader_if #(.DATA_W(8), .BYTES(4)) ifc2 ();

    assign ifc2.fifo_data  = ifc.fifo_data;
    assign ifc2.fifo_empty = ifc.fifo_empty;
    assign ifc2.word_ready = ifc.word_ready;

    fifo_word_reader #(.DATA_W(8), .BYTES(4), .CNT_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush_i    (flush),
        .clr_i      (clr),
        .word_cnt_o (wordCnt),
        .bus        (ifc.master)
    );

    fifo_word_reader #(.DATA_W(8), .BYTES(4), .CNT_W(2)) dut2 (
        .clk        (clk),
        .rst        (rst),
        .flush_i    (flush),
        .clr_i      (clr),
        .word_cnt_o (wordCnt2),
        .bus        (ifc2.master)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [34:0] mkRec(input int nBytes, input logic [31:0] w);
        return {3'(nBytes), w};
    endfunction

    task automatic refreshFifo();
        ifc.fifo_empty = (fq.size() == 0);
        ifc.fifo_data  = (fq.size() == 0) ? 8'h00 : fq[0];
    endtask

    // FIFO model: pops or clears one time unit after the edge that requested it.
    initial begin
        logic doPop, doClr;
        forever begin
            @(posedge clk);
            doPop = ifc.fifo_rd_en;
            doClr = ifc.fifo_clr;
            #1;
            if (doClr) fq.delete();
            else if (doPop && fq.size() > 0) void'(fq.pop_front());
            refreshFifo();
        end
    end

    always @(posedge clk) begin
        if (!rst && !clr && ifc.word_valid && ifc.word_ready)
            gotQ.push_back({ifc.word_bytes, ifc.word_out});
    end

    task automatic applyStimulus(input logic [7:0] b);
        fq.push_back(b);
        refreshFifo();
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic checkCounts(input string tag);
        checkOutput({tag, "_cnt"}, 64'(wordCnt), 64'(expCnt % 65536));
        checkOutput({tag, "_cnt2"}, 64'(wordCnt2), 64'(expCnt % 4));
    endtask

    initial begin
        logic [4:0] pattern;
        int n, good, sawBubble, guard, nRand, vcount;
        logic [31:0] w;

        rst = 1'b1;
        flush = 1'b0;
        clr = 1'b0;
        ifc.word_ready = 1'b0;
        refreshFifo();

        #2;
        checkOutput("reset_valid", 64'(ifc.word_valid), 64'd0);
        checkOutput("reset_word", 64'(ifc.word_out), 64'd0);
        checkOutput("reset_bytes", 64'(ifc.word_bytes), 64'd0);
        checkOutput("reset_fifo_clr", 64'(ifc.fifo_clr), 64'd0);
        checkOutput("reset_rd_en", 64'(ifc.fifo_rd_en), 64'd0);
        checkCounts("reset");
        tick(1);
        rst = 1'b0;
        tick(1);

        // Full word with downstream always ready.
        $display("[TB] full word");
        ifc.word_ready = 1'b1;
        applyStimulus(8'h11); applyStimulus(8'h22); applyStimulus(8'h33); applyStimulus(8'h44);
        expQ.push_back(mkRec(4, 32'h44332211));
        for (int i = 0; i < 5; i++) begin
            #1;
            pattern[i] = ifc.fifo_rd_en;
            if (i == 4) begin
                checkOutput("full_valid", 64'(ifc.word_valid), 64'd1);
                checkOutput("full_word", 64'(ifc.word_out), 64'h44332211);
                checkOutput("full_bytes", 64'(ifc.word_bytes), 64'd4);
            end
            tick(1);
        end
        checkOutput("full_rd_pattern", 64'(pattern), 64'b01111);
        expCnt++;
        #1;
        checkCounts("full");
        checkOutput("full_valid_after", 64'(ifc.word_valid), 64'd0);

        // Backpressure with two words queued.
        $display("[TB] backpressure");
        ifc.word_ready = 1'b0;
        for (int b = 1; b <= 8; b++) applyStimulus(8'(b * 8'h11));
        expQ.push_back(mkRec(4, 32'h44332211));
        expQ.push_back(mkRec(4, 32'h88776655));
        tick(4);
        good = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (ifc.word_valid && ifc.word_out == 32'h44332211 && !ifc.fifo_rd_en) good++;
            tick(1);
        end
        checkOutput("bp_stable_cycles", 64'(good), 64'd10);
        ifc.word_ready = 1'b1;
        n = 0;
        sawBubble = 0;
        do begin
            tick(1);
            n++;
            #1;
            if (n == 1) sawBubble = (!ifc.word_valid && ifc.fifo_rd_en) ? 1 : 0;
        end while (!ifc.word_valid && n < 20);
        checkOutput("bp_first_pop_after_bubble", 64'(sawBubble), 64'd1);
        checkOutput("bp_cycles_to_second", 64'(n), 64'd5);
        checkOutput("bp_second_word", 64'(ifc.word_out), 64'h88776655);
        expCnt += 2;
        tick(1);
        #1;
        checkCounts("bp");

        // Flush of a partial word, byte popped in the flush cycle included.
        $display("[TB] flush partial");
        tick(1);
        applyStimulus(8'hAA); applyStimulus(8'hBB);
        expQ.push_back(mkRec(2, 32'h0000BBAA));
        tick(1);
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        #1;
        checkOutput("flush_valid", 64'(ifc.word_valid), 64'd1);
        checkOutput("flush_word", 64'(ifc.word_out), 64'h0000BBAA);
        checkOutput("flush_bytes", 64'(ifc.word_bytes), 64'd2);
        expCnt++;
        tick(1);
        #1;
        checkCounts("flush");
        checkOutput("wrap_cnt2_zero", 64'(wordCnt2), 64'd0);
        tick(1);
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        vcount = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (ifc.word_valid) vcount++;
            tick(1);
        end
        checkOutput("empty_flush_no_word", 64'(vcount), 64'd0);
        checkCounts("empty_flush");

        // Clear with three bytes packed.
        $display("[TB] clear");
        applyStimulus(8'hC1); applyStimulus(8'hC2); applyStimulus(8'hC3);
        tick(4);
        clr = 1'b1;
        #1;
        checkOutput("clr_cycle_fifo_clr", 64'(ifc.fifo_clr), 64'd0);
        tick(1);
        clr = 1'b0;
        #1;
        checkOutput("clr_fifo_clr_pulse", 64'(ifc.fifo_clr), 64'd1);
        checkOutput("clr_word_zero", 64'(ifc.word_out), 64'd0);
        checkOutput("clr_valid", 64'(ifc.word_valid), 64'd0);
        checkCounts("clr");
        tick(1);
        #1;
        checkOutput("clr_fifo_clr_end", 64'(ifc.fifo_clr), 64'd0);
        tick(1);
        applyStimulus(8'h01); applyStimulus(8'h02); applyStimulus(8'h03); applyStimulus(8'h04);
        expQ.push_back(mkRec(4, 32'h04030201));
        tick(4);
        #1;
        checkOutput("clr_next_word", 64'(ifc.word_out), 64'h04030201);
        checkOutput("clr_next_bytes", 64'(ifc.word_bytes), 64'd4);
        expCnt++;
        tick(1);
        #1;
        checkCounts("clr_next");

        // CLR and handshake in the same HOLD cycle: word dropped.
        $display("[TB] clr vs handshake");
        ifc.word_ready = 1'b0;
        applyStimulus(8'hE1); applyStimulus(8'hE2); applyStimulus(8'hE3); applyStimulus(8'hE4);
        tick(4);
        #1;
        checkOutput("cvh_hold", 64'(ifc.word_valid), 64'd1);
        tick(1);
        clr = 1'b1;
        ifc.word_ready = 1'b1;
        tick(1);
        clr = 1'b0;
        ifc.word_ready = 1'b0;
        #1;
        checkOutput("cvh_valid_dropped", 64'(ifc.word_valid), 64'd0);
        checkOutput("cvh_fifo_clr", 64'(ifc.fifo_clr), 64'd1);
        checkCounts("cvh");
        tick(2);

        // Asynchronous reset between edges mid-word.
        $display("[TB] async reset");
        ifc.word_ready = 1'b1;
        applyStimulus(8'hD1); applyStimulus(8'hD2);
        tick(2);
        #1;
        checkOutput("ar_partial_word", 64'(ifc.word_out), 64'h0000D2D1);
        #1;
        rst = 1'b1;
        #1;
        expCnt = 0;
        checkOutput("ar_word_zero", 64'(ifc.word_out), 64'd0);
        checkOutput("ar_valid", 64'(ifc.word_valid), 64'd0);
        checkOutput("ar_rd_en", 64'(ifc.fifo_rd_en), 64'd0);
        checkOutput("ar_fifo_clr", 64'(ifc.fifo_clr), 64'd0);
        checkCounts("ar");
        tick(1);
        rst = 1'b0;
        tick(1);
        applyStimulus(8'h5A); applyStimulus(8'h5B); applyStimulus(8'h5C); applyStimulus(8'h5D);
        expQ.push_back(mkRec(4, 32'h5D5C5B5A));
        tick(4);
        #1;
        checkOutput("ar_after_word", 64'(ifc.word_out), 64'h5D5C5B5A);
        expCnt++;
        tick(1);
        #1;
        checkCounts("ar_after");

        // Randomized stream with random gaps and backpressure, final flush.
        $display("[TB] random stream");
        nRand = 41;
        n = 0;
        guard = 0;
        while ((n < nRand || fq.size() > 0 || ifc.word_valid) && guard < 3000) begin
            tick(1);
            guard++;
            ifc.word_ready = 1'($urandom_range(0, 1));
            if (n < nRand && $urandom_range(0, 2) != 0) begin
                randBytes.push_back(8'($urandom));
                applyStimulus(randBytes[n]);
                n++;
            end
        end
        checkOutput("rand_drain_in_budget", 64'(guard < 3000), 64'd1);
        ifc.word_ready = 1'b1;
        for (int g = 0; g + 4 <= nRand; g += 4) begin
            w = {randBytes[g+3], randBytes[g+2], randBytes[g+1], randBytes[g]};
            expQ.push_back(mkRec(4, w));
            expCnt++;
        end
        if (nRand % 4 != 0) begin
            w = '0;
            for (int k = 0; k < nRand % 4; k++) w[k*8 +: 8] = randBytes[(nRand/4)*4 + k];
            expQ.push_back(mkRec(nRand % 4, w));
            expCnt++;
        end
        tick(1);
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        tick(3);
        #1;
        checkCounts("rand");

        checkOutput("word_total", 64'(gotQ.size()), 64'(expQ.size()));
        for (int i = 0; i < expQ.size() && i < gotQ.size(); i++)
            checkOutput($sformatf("word_%0d", i), 64'(gotQ[i]), 64'(expQ[i]));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
